// File: rtl/spi_master_cfg_if.sv
// Wishbone slave-side bus bundle for spi_master_cfg: 16-bit data, 2-bit word address.
interface spi_master_cfg_if;
  logic [1:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/spi_master_cfg.sv
// Wishbone SPI master with programmable divider, all four CPOL/CPHA modes,
// selectable bit order, software slave selects and a sticky-done interrupt.
module spi_master_cfg #(
  parameter int unsigned NUM_SS  = 8,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  spi_master_cfg_if.slave   wb,
  output logic              irq_o,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q;
  logic              ack_q;
  logic [15:0]       dat_q;
  logic              cpol_q, cpha_q, lsb_q, ie_q;
  logic [DIV_W-1:0]  div_q, hcnt_q;
  logic [NUM_SS-1:0] ss_q;
  logic              done_q, ovr_q, done_d, ovr_d;
  logic [7:0]        rx_q, rxsh_q, sr_q;
  logic              sclk_q, mosi_q;
  logic [4:0]        edge_q;

  logic        access, wr, tick, lead, last, fin, idle_now;
  logic        wr_data, start, clr, smp, shf;
  logic [15:0] rd_d, ctrl_rd, ss_rd, ss_mask;
  logic [7:0]  rx_next, sr_shift, tx_rest;
  logic        sr_out, tx_first;

  always_comb begin
    access   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    wr       = access & wb.wb_we_i;
    tick     = (state_q == S_RUN) && (hcnt_q == '0);
    lead     = ~edge_q[0];
    last     = (edge_q == 5'd1);
    fin      = tick & last;
    // The completing cycle counts as idle so a DATA write there chains a new transfer.
    idle_now = (state_q == S_IDLE) | fin;
    wr_data  = wr && (wb.wb_adr_i == 2'd0) && wb.wb_sel_i[0];
    start    = wr_data & idle_now;
    clr      = wr && (wb.wb_adr_i == 2'd3) && wb.wb_sel_i[0];
    smp      = lead ^ cpha_q;
    shf      = ~smp & ~last;

    sr_out   = lsb_q ? sr_q[0] : sr_q[7];
    sr_shift = lsb_q ? {1'b0, sr_q[7:1]} : {sr_q[6:0], 1'b0};
    rx_next  = lsb_q ? {miso, rxsh_q[7:1]} : {rxsh_q[6:0], miso};
    tx_first = lsb_q ? wb.wb_dat_i[0] : wb.wb_dat_i[7];
    tx_rest  = lsb_q ? {1'b0, wb.wb_dat_i[7:1]} : {wb.wb_dat_i[6:0], 1'b0};

    done_d   = (done_q & ~(clr & wb.wb_dat_i[1])) | fin;
    ovr_d    = (ovr_q  & ~(clr & wb.wb_dat_i[2])) | (wr_data & ~idle_now);

    ctrl_rd              = '0;
    ctrl_rd[8 +: DIV_W]  = div_q;
    ctrl_rd[3:0]         = {ie_q, lsb_q, cpha_q, cpol_q};
    ss_rd                = '0;
    ss_rd[NUM_SS-1:0]    = ss_q;
    ss_mask              = {{8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};

    case (wb.wb_adr_i)
      2'd0:    rd_d = {8'h00, rx_q};
      2'd1:    rd_d = ctrl_rd;
      2'd2:    rd_d = ss_rd;
      default: rd_d = {13'd0, ovr_q, done_q, state_q == S_RUN};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      ie_q    <= 1'b0;
      div_q   <= DIV_W'(DIV_RST);
      hcnt_q  <= '0;
      ss_q    <= '1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rx_q    <= '0;
      rxsh_q  <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      edge_q  <= '0;
    end else begin
      ack_q  <= access;
      done_q <= done_d;
      ovr_q  <= ovr_d;
      if (access) dat_q <= rd_d;

      if (wr && (wb.wb_adr_i == 2'd1)) begin
        if (wb.wb_sel_i[0]) begin
          ie_q <= wb.wb_dat_i[3];
          if (idle_now) {lsb_q, cpha_q, cpol_q} <= wb.wb_dat_i[2:0];
        end
        if (wb.wb_sel_i[1] && idle_now) div_q <= wb.wb_dat_i[8 +: DIV_W];
      end

      if (wr && (wb.wb_adr_i == 2'd2))
        ss_q <= (ss_q & ~ss_mask[NUM_SS-1:0]) | (wb.wb_dat_i[NUM_SS-1:0] & ss_mask[NUM_SS-1:0]);

      case (state_q)
        S_IDLE: sclk_q <= cpol_q;
        S_RUN: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            hcnt_q <= div_q;
            edge_q <= edge_q - 5'd1;
            if (smp) rxsh_q <= rx_next;
            if (shf) begin
              mosi_q <= sr_out;
              sr_q   <= sr_shift;
            end
            // With cpha=1 the final edge is itself a sample edge.
            if (last) begin
              state_q <= S_IDLE;
              rx_q    <= cpha_q ? rx_next : rxsh_q;
            end
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (start) begin
        state_q <= S_RUN;
        edge_q  <= 5'd16;
        hcnt_q  <= div_q;
        if (!cpha_q) begin
          mosi_q <= tx_first;
          sr_q   <= tx_rest;
        end else begin
          sr_q   <= wb.wb_dat_i[7:0];
        end
      end
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = done_q & ie_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign ss          = ss_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: behavioural SPI slave plus randomized transfers.
module tb_spi_master_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq, sclk, mosi, miso;
  logic [7:0] ss;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;

  spi_master_cfg_if bus ();

  spi_master_cfg #(.NUM_SS(8), .DIV_W(8), .DIV_RST(1)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb       (bus),
    .irq_o    (irq),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .ss       (ss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bit placed on the wire at position idx (0 = first) for byte b.
  function automatic logic wire_bit(input logic [7:0] b, input int idx, input logic lsb);
    if (idx < 0 || idx > 7) return 1'b0;
    return lsb ? b[idx] : b[7-idx];
  endfunction

  // Behavioural slave: drives its byte in wire order, records what it sees on mosi.
  logic       s_arm = 1'b0;
  logic       s_cpol, s_cpha, s_lsb;
  logic [7:0] s_byte = 8'h00;
  int         s_idx = 0;
  logic       cap[$];

  assign miso = wire_bit(s_byte, s_idx, s_lsb);

  always @(sclk) begin : slave
    logic lead;
    if (s_arm) begin
      lead = (sclk != s_cpol);
      if (!s_cpha) begin
        if (lead) cap.push_back(mosi);
        else s_idx++;
      end else begin
        if (lead) s_idx++;
        else cap.push_back(mosi);
      end
    end
  end

  task automatic slave_arm(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] b);
    s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; s_byte = b;
    s_idx  = cpha ? -1 : 0;
    cap.delete();
    s_arm  = 1'b1;
  endtask

  task automatic wb_xfer(input logic [1:0] adr, input logic we, input logic [15:0] wdat,
                         input logic [1:0] sel, output logic [15:0] rdat);
    int n;
    if (bus.wb_ack_o === 1'b1) begin @(posedge clk); #1; end
    bus.wb_adr_i = adr; bus.wb_we_i = we; bus.wb_dat_i = wdat; bus.wb_sel_i = sel;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.wb_ack_o !== 1'b1 && n < 8);
    n_checks++;
    if (bus.wb_ack_o !== 1'b1 || n != 1) begin
      n_errors++;
      $display("FAIL wb_ack adr=%0d got_cycles=%0d want=1", adr, n);
    end
    rdat = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic check_mosi(input logic [7:0] tx, input logic lsb, input string tag);
    logic [7:0] got_w, exp_w;
    for (int i = 0; i < 8; i++) begin
      got_w[i] = (i < cap.size()) ? cap[i] : 1'bx;
      exp_w[i] = wire_bit(tx, i, lsb);
    end
    n_checks++;
    if (cap.size() != 8 || got_w !== exp_w) begin
      n_errors++;
      $display("FAIL %s mosi_bits got=%b (n=%0d) want=%b", tag, got_w, cap.size(), exp_w);
    end
  endtask

  task automatic run_xfer(input logic cpol, input logic cpha, input logic lsb, input int unsigned div,
                          input logic [7:0] tx, input logic [7:0] sb, input string tag);
    logic [15:0] r;
    int unsigned t0, lat;
    wb_xfer(2'd1, 1'b1, {8'(div), 4'h0, 1'b1, lsb, cpha, cpol}, 2'b11, r);
    wb_xfer(2'd3, 1'b1, 16'h0006, 2'b01, r);
    @(posedge clk); #1;
    n_checks++;
    if (sclk !== cpol) begin n_errors++; $display("FAIL %s idle_sclk got=%b want=%b", tag, sclk, cpol); end
    slave_arm(cpol, cpha, lsb, sb);
    wb_xfer(2'd0, 1'b1, {8'h00, tx}, 2'b01, r);
    t0 = cyc;
    while (irq !== 1'b1 && (cyc - t0) < 16 * (div + 1) + 40) begin @(posedge clk); #1; end
    lat = cyc - t0;
    s_arm = 1'b0;
    n_checks++;
    if (irq !== 1'b1 || lat != 16 * (div + 1)) begin
      n_errors++;
      $display("FAIL %s latency got=%0d irq=%b want=%0d", tag, lat, irq, 16 * (div + 1));
    end
    check_mosi(tx, lsb, tag);
    n_checks++;
    if (sclk !== cpol || mosi !== wire_bit(tx, 7, lsb)) begin
      n_errors++;
      $display("FAIL %s idle_lines got sclk=%b mosi=%b want sclk=%b mosi=%b",
               tag, sclk, mosi, cpol, wire_bit(tx, 7, lsb));
    end
    wb_xfer(2'd0, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== {8'h00, sb}) begin n_errors++; $display("FAIL %s rx got=%h want=%h", tag, r, {8'h00, sb}); end
    wb_xfer(2'd3, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0002) begin n_errors++; $display("FAIL %s status got=%h want=0002", tag, r); end
  endtask

  task automatic test_reset();
    logic [15:0] r;
    n_checks++;
    if (sclk !== 1'b0 || mosi !== 1'b1 || ss !== 8'hFF || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pins got sclk=%b mosi=%b ss=%h irq=%b want 0 1 ff 0", sclk, mosi, ss, irq);
    end
    wb_xfer(2'd1, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0100) begin n_errors++; $display("FAIL reset_ctrl got=%h want=0100", r); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL ack_width got=%b want=0", bus.wb_ack_o); end
    wb_xfer(2'd3, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0000) begin n_errors++; $display("FAIL reset_status got=%h want=0000", r); end
    wb_xfer(2'd2, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h00FF) begin n_errors++; $display("FAIL reset_ss got=%h want=00ff", r); end
  endtask

  task automatic test_mode0_msb();
    logic [15:0] r;
    wb_xfer(2'd2, 1'b1, 16'h00FE, 2'b01, r);
    n_checks++;
    if (ss !== 8'hFE) begin n_errors++; $display("FAIL ss_write got=%h want=fe", ss); end
    run_xfer(1'b0, 1'b0, 1'b0, 1, 8'hA5, 8'h3C, "mode0_msb");
  endtask

  task automatic test_mode3_lsb();
    run_xfer(1'b1, 1'b1, 1'b1, 0, 8'h01, 8'h81, "mode3_lsb");
  endtask

  task automatic test_irq_clear();
    logic [15:0] r;
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_set got=%b want=1", irq); end
    wb_xfer(2'd3, 1'b1, 16'h0002, 2'b01, r);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_clear got=%b want=0", irq); end
    wb_xfer(2'd3, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0000) begin n_errors++; $display("FAIL done_clear status got=%h want=0000", r); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 8'($urandom), 8'($urandom), "random");
    end
  endtask

  task automatic test_overrun();
    logic [15:0] r;
    int unsigned t0, lat;
    wb_xfer(2'd1, 1'b1, 16'h0108, 2'b11, r);
    wb_xfer(2'd3, 1'b1, 16'h0006, 2'b01, r);
    slave_arm(1'b0, 1'b0, 1'b0, 8'h5A);
    wb_xfer(2'd0, 1'b1, 16'h00C3, 2'b01, r);
    t0 = cyc;
    @(posedge clk); #1;
    wb_xfer(2'd0, 1'b1, 16'h0055, 2'b01, r);
    wb_xfer(2'd1, 1'b1, 16'h0708, 2'b11, r);
    while (irq !== 1'b1 && (cyc - t0) < 80) begin @(posedge clk); #1; end
    lat = cyc - t0;
    s_arm = 1'b0;
    n_checks++;
    if (irq !== 1'b1 || lat != 32) begin n_errors++; $display("FAIL overrun latency got=%0d want=32", lat); end
    check_mosi(8'hC3, 1'b0, "overrun");
    wb_xfer(2'd0, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h005A) begin n_errors++; $display("FAIL overrun rx got=%h want=005a", r); end
    wb_xfer(2'd3, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0006) begin n_errors++; $display("FAIL overrun status got=%h want=0006", r); end
    wb_xfer(2'd1, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0108) begin n_errors++; $display("FAIL busy_ctrl got=%h want=0108", r); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    wb_xfer(2'd1, 1'b1, 16'h0008, 2'b11, r);
    wb_xfer(2'd3, 1'b1, 16'h0006, 2'b01, r);
    slave_arm(1'b0, 1'b0, 1'b0, 8'h00);
    wb_xfer(2'd0, 1'b1, 16'h000F, 2'b01, r);
    repeat (15) @(posedge clk);
    #1;
    // Access edge of this write coincides with the edge busy falls.
    wb_xfer(2'd0, 1'b1, 16'h0096, 2'b01, r);
    check_mosi(8'h0F, 1'b0, "b2b_first");
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL b2b_done got=%b want=1", irq); end
    slave_arm(1'b0, 1'b0, 1'b0, 8'h69);
    repeat (16) @(posedge clk);
    #1;
    s_arm = 1'b0;
    check_mosi(8'h96, 1'b0, "b2b_second");
    wb_xfer(2'd3, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0002) begin n_errors++; $display("FAIL b2b status got=%h want=0002", r); end
    wb_xfer(2'd0, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0069) begin n_errors++; $display("FAIL b2b rx got=%h want=0069", r); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    wb_xfer(2'd1, 1'b1, 16'h0308, 2'b11, r);
    wb_xfer(2'd2, 1'b1, 16'h00FE, 2'b01, r);
    wb_xfer(2'd3, 1'b1, 16'h0006, 2'b01, r);
    slave_arm(1'b0, 1'b0, 1'b0, 8'hC7);
    wb_xfer(2'd0, 1'b1, 16'h00AA, 2'b01, r);
    repeat (28) @(posedge clk);
    #1;
    n_checks++;
    if (sclk !== 1'b1) begin n_errors++; $display("FAIL edge7_sclk got=%b want=1", sclk); end
    s_arm = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sclk !== 1'b0 || ss !== 8'hFF || mosi !== 1'b1 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got sclk=%b ss=%h mosi=%b irq=%b want 0 ff 1 0", sclk, ss, mosi, irq);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    wb_xfer(2'd3, 1'b0, 16'h0000, 2'b11, r);
    n_checks++;
    if (r !== 16'h0000) begin n_errors++; $display("FAIL post_reset status got=%h want=0000", r); end
    run_xfer(1'b0, 1'b0, 1'b0, 3, 8'hF0, 8'($urandom), "after_reset");
  endtask

  initial begin
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0; bus.wb_sel_i = '0;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_irq_clear();
    test_random();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised Wishbone SPI master, the successor to the fixed mode-3, divide-by-4, 8-select SPI core. It adds:
- a register-mapped programmable clock divider;
- all four CPOL/CPHA modes;
- MSB- or LSB-first shifting;
- a parametrised slave-select count;
- sticky status flags and a completion interrupt.

It sits on the 16-bit Wishbone peripheral bus, one instance per SPI port.

Parameters:
NUM_SS, 8, number of active-low slave-select outputs (1..16)
DIV_W, 8, width of the clock divider field (1..8)
DIV_RST, 1, reset value of the divider field

Ports:
wb_clk_i  input  1  system clock; all logic on the rising edge
wb_rst_i  input  1  asynchronous, active-low reset
wb_adr_i  input  2  register select (word address)
wb_dat_i  input  16  write data
wb_dat_o  output  16  read data
wb_we_i  input  1  write enable
wb_sel_i  input  2  byte lanes
wb_stb_i  input  1  strobe
wb_cyc_i  input  1  cycle
wb_ack_o  output  1  acknowledge
irq_o  output  1  level interrupt, = done & ie
sclk  output  1  serial clock
mosi  output  1  master out
miso  input  1  master in
ss  output  NUM_SS  slave selects, active-low, software driven

Behaviour:
Register map (wb_adr_i):
- 0 DATA: write with sel[0] = 1 while idle loads the TX byte and starts a transfer. Read returns the RX byte in [7:0], zeros in [15:8].
- 1 CTRL: [0] cpol, [1] cpha, [2] lsb_first, [3] ie, [8+DIV_W-1:8] div. Writes honour byte lanes. While busy only ie updates; the other fields are ignored.
- 2 SS: [NUM_SS-1:0] written directly to ss on lane-qualified writes; unused bits read 0.
- 3 STATUS: [0] busy (RO), [1] done (sticky), [2] overrun (sticky). Writing 1 to bit 1 or bit 2 clears that bit.

Wishbone handshake:
- Every access is acked: wb_ack_o asserts exactly 1 cycle after stb & cyc is first seen, for 1 cycle.
- The access is not re-acked in the cycle after an ack. Zero wait states otherwise, no stalling on transfers.
- Register writes take effect on the ack cycle edge.
- wb_dat_o is registered, valid with ack.

Overrun:
- A DATA write while busy is dropped and sets overrun.
- The TX/RX shift state is unaffected.

Clocking:
- Half-period = div+1 wb_clk_i cycles. div = 0 is legal (sclk = clk/2).
- Idle sclk = cpol. A CTRL write of cpol while idle updates sclk on the next cycle.

Transfer FSM (IDLE -> RUN -> IDLE):
- Start: busy = 1, the bit counter is loaded with 16 edges, and the half-period counter is loaded with div.
- Each time the half-period counter reaches 0, sclk toggles and the counter reloads.
- cpha = 0:
  - mosi drives the first bit on the start edge.
  - miso is sampled on the odd (leading) edges.
  - mosi shifts on the even (trailing) edges, except the last.
- cpha = 1:
  - mosi shifts on leading edges, starting with the first bit.
  - miso is sampled on trailing edges.
- lsb_first selects bit 0 first/shift-right; otherwise bit 7 first/shift-left.
- Received bits assemble so the RX byte has the wire order mapped to natural bit significance.
- After the 16th edge:
  - RX is updated;
  - busy = 0 and done = 1 on the same cycle;
  - sclk is back at cpol.
- Total latency from the start edge to busy falling = 16*(div+1) cycles.

Idle and concurrent events:
- mosi holds its last value in IDLE; it is 1 after reset.
- A done-clear write in the same cycle as completion: done stays 1, because set wins.
- A DATA write on the cycle busy falls is seen as idle and starts a new transfer, with no overrun.
- ss is independent of the FSM. Software must assert the select before DATA and release it after done.

Reset (wb_rst_i = 0, asynchronous):
- Outputs: sclk = 0, mosi = 1, ss = all ones, wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
- Registers: CTRL = {div = DIV_RST, others 0}, RX = 0, STATUS = 0.
- Reset mid-transfer aborts immediately. After release the block is idle with no done flag.

Test Plan:
- Reset defaults: after reset, read CTRL -> 16'h0100 (DIV_RST = 1); read STATUS -> 0; read SS -> 8'hFF; sclk = 0, mosi = 1.
- Mode 0, MSB-first, div = 1, slave returns 8'h3C: write DATA = 8'hA5 -> mosi sequence 1,0,1,0,0,1,0,1, sampled on rising sclk edges; busy for 32 cycles; RX = 8'h3C; done = 1.
- Mode 3, LSB-first, div = 0, slave returns 8'h81: write DATA = 8'h01 -> sclk idles high, period = 2 clk; first mosi bit = 1; busy 16 cycles; RX = 8'h81.
- With ie = 1, a transfer completes -> irq_o rises with done. Write STATUS = 16'h0002 -> done = 0 and irq_o = 0 on the next cycle.
- Write DATA = 8'h55 while busy -> transfer in flight still shifts the original byte; overrun = 1; a CTRL div write in the same window is ignored.
- Assert reset at edge 7 of a div = 3 transfer -> sclk = 0, busy = 0, ss = 8'hFF immediately. After release a new transfer of 8'hF0 completes correctly.
